// File: rtl/proc_debug_scanner_pkg.sv
// Shared types and helpers for the debug scanner: FSM state encoding, default widths and
// selector clamping.
package proc_debug_scanner_pkg;

   typedef enum logic [1:0] {
      StSelect  = 2'd0,
      StSettle  = 2'd1,
      StCapture = 2'd2,
      StDwell   = 2'd3
   } scan_state_e;

   localparam int unsigned DefLedW      = 16;
   localparam int unsigned DefSsdW      = 13;
   localparam int unsigned DefNumLedSel = 4;
   localparam int unsigned DefNumSsdSel = 16;

   // Out-of-range manual requests pin to the last valid code.
   function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned num);
      return (sel >= num) ? num - 1 : sel;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/proc_debug_scanner_if.sv
// Board-side debug bus: switch requests and core debug values in, selectors and captured
// snapshots out.
interface proc_debug_scanner_if
   import proc_debug_scanner_pkg::*;
#(
   parameter int unsigned LED_W       = DefLedW,
   parameter int unsigned SSD_W       = DefSsdW,
   parameter int unsigned NUM_LED_SEL = DefNumLedSel,
   parameter int unsigned NUM_SSD_SEL = DefNumSsdSel
);
   localparam int unsigned LedSelW = $clog2(NUM_LED_SEL);
   localparam int unsigned SsdSelW = $clog2(NUM_SSD_SEL);

   logic               mode_auto;
   logic               hold;
   logic [LedSelW-1:0] man_led_sel;
   logic [SsdSelW-1:0] man_ssd_sel;
   logic [LED_W-1:0]   core_leds;
   logic [SSD_W-1:0]   core_ssd;
   logic [LedSelW-1:0] led_sel;
   logic [SsdSelW-1:0] ssd_sel;
   logic [LED_W-1:0]   leds_q;
   logic [SSD_W-1:0]   ssd_q;
   logic               sample_valid;
   logic               sweep_done;

   modport master (
      input  mode_auto, hold, man_led_sel, man_ssd_sel, core_leds, core_ssd,
      output led_sel, ssd_sel, leds_q, ssd_q, sample_valid, sweep_done
   );

   modport slave (
      output mode_auto, hold, man_led_sel, man_ssd_sel, core_leds, core_ssd,
      input  led_sel, ssd_sel, leds_q, ssd_q, sample_valid, sweep_done
   );

endinterface

// File: rtl/proc_debug_scanner_timer.sv
// Loadable down-counter shared by the settle and dwell phases; done flags a count of one.
module proc_debug_scanner_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_done
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_done = (r_count == WIDTH'(1));

endmodule

// File: rtl/proc_debug_scanner.sv
// Debug scanner: drives the core's debug selectors, waits for the debug mux to settle, then
// snapshots leds/ssd. Auto mode sweeps all selector pairs; manual mode tracks the switches.
module proc_debug_scanner
   import proc_debug_scanner_pkg::*;
#(
   parameter int unsigned LED_W         = DefLedW,
   parameter int unsigned SSD_W         = DefSsdW,
   parameter int unsigned NUM_LED_SEL   = DefNumLedSel,
   parameter int unsigned NUM_SSD_SEL   = DefNumSsdSel,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned DWELL_CYCLES  = 50_000_000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   proc_debug_scanner_if.master  io_dbg
);

   localparam int unsigned LedSelW = $clog2(NUM_LED_SEL);
   localparam int unsigned SsdSelW = $clog2(NUM_SSD_SEL);
   localparam int unsigned TimerW  = $clog2(max_u(SETTLE_CYCLES, DWELL_CYCLES) + 1);

   scan_state_e        r_state, w_state_next;
   logic [LedSelW-1:0] r_led_sel, w_led_sel_next;
   logic [SsdSelW-1:0] r_ssd_sel, w_ssd_sel_next;
   logic [LED_W-1:0]   r_leds_q;
   logic [SSD_W-1:0]   r_ssd_q;
   logic               r_sample_valid, r_sweep_done, w_sweep_done_next;
   logic               w_capture, w_tmr_load, w_tmr_en, w_tmr_done;
   logic [TimerW-1:0]  w_tmr_load_val;

   proc_debug_scanner_timer #(
      .WIDTH (TimerW)
   ) u_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_load_val),
      .i_en       (w_tmr_en),
      .o_done     (w_tmr_done)
   );

   always_comb begin
      w_state_next      = r_state;
      w_led_sel_next    = r_led_sel;
      w_ssd_sel_next    = r_ssd_sel;
      w_sweep_done_next = 1'b0;
      w_capture         = 1'b0;
      w_tmr_load        = 1'b0;
      w_tmr_en          = 1'b0;
      w_tmr_load_val    = TimerW'(SETTLE_CYCLES);
      unique case (r_state)
         StSelect: begin
            if (!io_dbg.mode_auto) begin
               w_led_sel_next = LedSelW'(clamp_sel(32'(io_dbg.man_led_sel), NUM_LED_SEL));
               w_ssd_sel_next = SsdSelW'(clamp_sel(32'(io_dbg.man_ssd_sel), NUM_SSD_SEL));
            end
            w_tmr_load   = 1'b1;
            w_state_next = StSettle;
         end
         StSettle: begin
            w_tmr_en = 1'b1;
            if (w_tmr_done) w_state_next = StCapture;
         end
         StCapture: begin
            w_capture = 1'b1;
            if (io_dbg.mode_auto) begin
               w_tmr_load     = 1'b1;
               w_tmr_load_val = TimerW'(DWELL_CYCLES);
               w_state_next   = StDwell;
            end else begin
               w_state_next = StSelect;
            end
         end
         StDwell: begin
            // Leaving auto mode abandons the dwell without touching the channel.
            if (!io_dbg.mode_auto) begin
               w_state_next = StSelect;
            end else if (!io_dbg.hold) begin
               w_tmr_en = 1'b1;
               if (w_tmr_done) begin
                  w_state_next = StSelect;
                  if (32'(r_ssd_sel) == NUM_SSD_SEL - 1) begin
                     w_ssd_sel_next = '0;
                     if (32'(r_led_sel) == NUM_LED_SEL - 1) begin
                        w_led_sel_next    = '0;
                        w_sweep_done_next = 1'b1;
                     end else begin
                        w_led_sel_next = r_led_sel + LedSelW'(1);
                     end
                  end else begin
                     w_ssd_sel_next = r_ssd_sel + SsdSelW'(1);
                  end
               end
            end
         end
         default: w_state_next = StSelect;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= StSelect;
         r_led_sel      <= '0;
         r_ssd_sel      <= '0;
         r_leds_q       <= '0;
         r_ssd_q        <= '0;
         r_sample_valid <= 1'b0;
         r_sweep_done   <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_led_sel      <= w_led_sel_next;
         r_ssd_sel      <= w_ssd_sel_next;
         r_sample_valid <= w_capture;
         r_sweep_done   <= w_sweep_done_next;
         if (w_capture) begin
            r_leds_q <= io_dbg.core_leds;
            r_ssd_q  <= io_dbg.core_ssd;
         end
      end
   end

   assign io_dbg.led_sel      = r_led_sel;
   assign io_dbg.ssd_sel      = r_ssd_sel;
   assign io_dbg.leds_q       = r_leds_q;
   assign io_dbg.ssd_q        = r_ssd_q;
   assign io_dbg.sample_valid = r_sample_valid;
   assign io_dbg.sweep_done   = r_sweep_done;

endmodule

// File: tb/tb_proc_debug_scanner.sv
// Scoreboard bench for proc_debug_scanner: directed scenarios push expected samples and sweep
// pulses; a negedge monitor pops and compares whenever the scanner presents one.
module tb_proc_debug_scanner;

   typedef struct {
      logic [1:0]  led_sel;
      logic [1:0]  ssd_sel;
      logic [15:0] leds;
      logic [12:0] ssd;
      int unsigned at_edge;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        ssd_follow;
   logic [12:0] ssd_base;
   int unsigned edge_cnt;
   int unsigned tests;
   int unsigned fails;
   exp_t        exp_q[$];
   int unsigned sweep_q[$];

   proc_debug_scanner_if #(
      .LED_W       (16),
      .SSD_W       (13),
      .NUM_LED_SEL (4),
      .NUM_SSD_SEL (3)
   ) dbg_if ();

   proc_debug_scanner #(
      .LED_W         (16),
      .SSD_W         (13),
      .NUM_LED_SEL   (4),
      .NUM_SSD_SEL   (3),
      .SETTLE_CYCLES (2),
      .DWELL_CYCLES  (4)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_dbg  (dbg_if.master)
   );

   // Core debug mux model: purely combinational in the selectors.
   assign dbg_if.core_leds = 16'({dbg_if.led_sel, dbg_if.ssd_sel});
   assign dbg_if.core_ssd  = ssd_follow ? (ssd_base ^ 13'({dbg_if.led_sel, dbg_if.ssd_sel}))
                                        : ssd_base;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (dbg_if.sample_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL sample_unexpected: got sel=(%0d,%0d) leds=%h ssd=%h at edge %0d, required no sample",
                        dbg_if.led_sel, dbg_if.ssd_sel, dbg_if.leds_q, dbg_if.ssd_q, edge_cnt);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (dbg_if.led_sel !== e.led_sel || dbg_if.ssd_sel !== e.ssd_sel ||
                   dbg_if.leds_q !== e.leds || dbg_if.ssd_q !== e.ssd || edge_cnt != e.at_edge) begin
                  fails++;
                  $display("FAIL sample: got sel=(%0d,%0d) leds=%h ssd=%h edge=%0d, required sel=(%0d,%0d) leds=%h ssd=%h edge=%0d",
                           dbg_if.led_sel, dbg_if.ssd_sel, dbg_if.leds_q, dbg_if.ssd_q, edge_cnt,
                           e.led_sel, e.ssd_sel, e.leds, e.ssd, e.at_edge);
               end
            end
         end
         if (dbg_if.sweep_done === 1'b1) begin
            tests++;
            if (sweep_q.size() == 0) begin
               fails++;
               $display("FAIL sweep_done_unexpected: got pulse at edge %0d, required none", edge_cnt);
            end else begin
               int unsigned want;
               want = sweep_q.pop_front();
               if (edge_cnt != want || dbg_if.led_sel !== 2'd0 || dbg_if.ssd_sel !== 2'd0) begin
                  fails++;
                  $display("FAIL sweep_done: got edge %0d sel=(%0d,%0d), required edge %0d sel=(0,0)",
                           edge_cnt, dbg_if.led_sel, dbg_if.ssd_sel, want);
               end
            end
         end
      end
   end

   task automatic push_exp(input int unsigned l, input int unsigned s, input logic [12:0] ssd,
                           input int unsigned at);
      exp_t e;
      e.led_sel = 2'(l);
      e.ssd_sel = 2'(s);
      e.leds    = 16'(l * 4 + s);
      e.ssd     = ssd;
      e.at_edge = at;
      exp_q.push_back(e);
   endtask

   task automatic check_zero(input string name);
      tests++;
      if ({dbg_if.led_sel, dbg_if.ssd_sel, dbg_if.leds_q, dbg_if.ssd_q,
           dbg_if.sample_valid, dbg_if.sweep_done} !== '0) begin
         fails++;
         $display("FAIL %s: got sel=(%0d,%0d) leds=%h ssd=%h valid=%b sweep=%b, required all zero",
                  name, dbg_if.led_sel, dbg_if.ssd_sel, dbg_if.leds_q, dbg_if.ssd_q,
                  dbg_if.sample_valid, dbg_if.sweep_done);
      end
   endtask

   // Asserts reset, drops pending expectations and checks the asynchronous clear.
   task automatic assert_reset(input string name);
      rst_n = 1'b0;
      exp_q.delete();
      sweep_q.delete();
      #1;
      check_zero(name);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || sweep_q.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      tests++;
      if (exp_q.size() != 0 || sweep_q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: got %0d samples and %0d sweeps pending, required 0 and 0",
                  name, exp_q.size(), sweep_q.size());
         exp_q.delete();
         sweep_q.delete();
      end
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      dbg_if.mode_auto   = 1'b1;
      dbg_if.hold        = 1'b0;
      dbg_if.man_led_sel = 2'd0;
      dbg_if.man_ssd_sel = 2'd0;
      ssd_follow         = 1'b1;
      ssd_base           = 13'h1000;

      // Power-on reset, then a full auto sweep plus the first sample after the wrap.
      assert_reset("reset_por");
      for (int k = 0; k <= 12; k++) begin
         int unsigned idx;
         idx = k % 12;
         push_exp(idx / 3, idx % 3, 13'h1000 ^ 13'(idx / 3 * 4 + idx % 3), 4 + 8 * k);
      end
      sweep_q.push_back(96);
      release_reset();
      drain("auto_sweep", 130);

      // Hold freezes the dwell timer for ten edges after one dwell decrement.
      assert_reset("reset_before_hold");
      ssd_base = 13'h0010;
      push_exp(0, 0, 13'h0010, 4);
      push_exp(0, 1, 13'h0011, 22);
      push_exp(0, 2, 13'h0012, 30);
      release_reset();
      repeat (5) @(posedge clk);
      @(negedge clk);
      dbg_if.hold = 1'b1;
      repeat (10) @(negedge clk);
      tests++;
      if (dbg_if.led_sel !== 2'd0 || dbg_if.ssd_sel !== 2'd0) begin
         fails++;
         $display("FAIL hold_no_advance: got sel=(%0d,%0d), required (0,0)",
                  dbg_if.led_sel, dbg_if.ssd_sel);
      end
      dbg_if.hold = 1'b0;
      drain("hold", 40);

      // Manual: ssd request 3 is out of range for three codes and clamps to 2; hold is ignored.
      assert_reset("reset_before_manual");
      dbg_if.mode_auto   = 1'b0;
      dbg_if.hold        = 1'b1;
      dbg_if.man_led_sel = 2'd2;
      dbg_if.man_ssd_sel = 2'b11;
      ssd_follow         = 1'b0;
      ssd_base           = 13'h1ABC;
      for (int k = 1; k <= 4; k++) push_exp(2, 2, 13'h1ABC, 4 * k);
      release_reset();
      drain("manual", 30);

      // Core output changes with the selector; the capture must see the settled value.
      assert_reset("reset_before_settle");
      dbg_if.mode_auto = 1'b1;
      dbg_if.hold      = 1'b0;
      ssd_follow       = 1'b1;
      ssd_base         = 13'h0555;
      push_exp(0, 0, 13'h0555, 4);
      push_exp(0, 1, 13'h0AAB, 12);
      release_reset();
      repeat (8) @(posedge clk);
      #1;
      ssd_base = 13'h0AAA;
      drain("settle_value", 20);

      // Asynchronous reset mid-dwell and mid-settle, then identical restart timing.
      assert_reset("reset_before_abort");
      ssd_base = 13'h0123;
      push_exp(0, 0, 13'h0123, 4);
      push_exp(0, 1, 13'h0122, 12);
      release_reset();
      repeat (13) @(posedge clk);
      #2;
      assert_reset("reset_mid_dwell");
      push_exp(0, 0, 13'h0123, 4);
      push_exp(0, 1, 13'h0122, 12);
      release_reset();
      repeat (10) @(posedge clk);
      #2;
      assert_reset("reset_mid_settle");
      push_exp(0, 0, 13'h0123, 4);
      push_exp(0, 1, 13'h0122, 12);
      release_reset();
      drain("restart", 20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
